// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the RAM port arbiter.
// No logic; pure definitions.
// No flow control of its own.
package ram_arbiter_pkg;

    localparam int          ADDR_W_DEF   = 22;
    localparam int          DATA_W       = 32;
    localparam int          MASK_W       = 4;
    localparam int          WDOG_W       = 16;
    localparam logic [31:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// One RAM-style request/response port (address, write, read channels).
// Combinational bundle, no latency of its own.
// Requests are levels held until the one-cycle ack/valid completion pulse.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [ADDR_W-1:0] address;
    logic              wr_enable;
    logic [DATA_W-1:0] wr_data;
    logic [MASK_W-1:0] wr_mask;
    logic              wr_ack;
    logic              rd_enable;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    // Requester side: drives the request, receives the completion.
    modport master (
        output address, wr_enable, wr_data, wr_mask, rd_enable,
        input  wr_ack, rd_data, rd_valid
    );

    // Responder side: receives the request, drives the completion.
    modport slave (
        input  address, wr_enable, wr_data, wr_mask, rd_enable,
        output wr_ack, rd_data, rd_valid
    );
endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin pick: one-hot grant from request pair and last owner.
// Purely combinational.
// No backpressure; a zero request vector yields a zero grant.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,   // index of the port granted most recently
    output logic [1:0] gnt_o
);

    // On a tie the port that did not own the previous transaction wins.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM controller port between CPU (p0) and VGA fetch (p1), round-robin.
// Latency: mem request from grant edge, completion pulse one cycle after the mem response.
// Requesters wait on level requests; a watchdog forces completion if memory never answers.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  p0,
    ram_arbiter_if.slave  p1,
    ram_arbiter_if.master mem,
    output logic [1:0]    grant,
    output logic          timeout_err
);

    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);

    state_t              state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                is_rd_q, is_rd_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                terr_q, terr_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    logic [1:0]          req;
    logic [1:0]          pick;
    logic                sel_wr;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [MASK_W-1:0]   sel_mask;
    logic                resp;
    logic [DATA_W-1:0]   rdat;

    assign req = {p1.wr_enable | p1.rd_enable, p0.wr_enable | p0.rd_enable};

    rr_pick2 u_pick (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    // Steer the winning port's request fields toward the capture registers.
    assign sel_wr    = pick[1] ? p1.wr_enable : p0.wr_enable;
    assign sel_addr  = pick[1] ? p1.address   : p0.address;
    assign sel_wdata = pick[1] ? p1.wr_data   : p0.wr_data;
    assign sel_mask  = pick[1] ? p1.wr_mask   : p0.wr_mask;

    // A response only counts in the state that matches it; strays are dropped.
    assign resp = (state_q == ST_WR && mem.wr_ack) || (state_q == ST_RD && mem.rd_valid);
    assign rdat = resp ? mem.rd_data : TIMEOUT_FILL;

    // Next-state: arbitration in IDLE, completion/watchdog in WR/RD, pulse in DONE.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        is_rd_d  = is_rd_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        wdog_d   = wdog_q;
        terr_d   = terr_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (pick != 2'b00) begin
                    // A port asking for both gets its write first; the read waits.
                    gnt_d   = pick;
                    is_rd_d = !sel_wr;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    mask_d  = sel_mask;
                    wdog_d  = '0;
                    state_d = sel_wr ? ST_WR : ST_RD;
                end
            end
            ST_WR, ST_RD: begin
                if (resp || wdog_q == WDOG_LIMIT) begin
                    if (state_q == ST_RD) begin
                        if (gnt_q[1]) rdata1_d = rdat;
                        else          rdata0_d = rdat;
                    end
                    if (!resp) terr_d = 1'b1;
                    last_d  = gnt_q[1];
                    state_d = ST_DONE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_DONE: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; port 1 counts as last owner so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 2'b00;
            is_rd_q  <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            wdog_q   <= '0;
            terr_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            is_rd_q  <= is_rd_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            wdog_q   <= wdog_d;
            terr_q   <= terr_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign mem.address   = addr_q;
    assign mem.wr_data   = wdata_q;
    assign mem.wr_mask   = mask_q;
    assign mem.wr_enable = (state_q == ST_WR);
    assign mem.rd_enable = (state_q == ST_RD);

    assign p0.wr_ack   = (state_q == ST_DONE) && gnt_q[0] && !is_rd_q;
    assign p0.rd_valid = (state_q == ST_DONE) && gnt_q[0] &&  is_rd_q;
    assign p0.rd_data  = rdata0_q;
    assign p1.wr_ack   = (state_q == ST_DONE) && gnt_q[1] && !is_rd_q;
    assign p1.rd_valid = (state_q == ST_DONE) && gnt_q[1] &&  is_rd_q;
    assign p1.rd_data  = rdata1_q;

    assign grant       = gnt_q;
    assign timeout_err = terr_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single system RAM port between the CPU busmaster (port 0) and the VGA scanout fetcher (port 1). It sits between the busmaster's `ram_*` interface, the VGA line fetcher and the RAM controller. It grants one transaction at a time, alternates grants round-robin and bounds every transaction with a timeout watchdog. On timeout the CPU still gets a completion, so a hung RAM controller never hangs the bus cycle.

## Interface
Parameters:
- `ADDR_W`, 22: word address width (32-bit words, 16 MB).
- `TIMEOUT`, 255: maximum cycles a granted transaction may wait for the memory response; must be 1..65535.

Ports (clock and reset first; `pN_*` exists for N = 0 and 1):
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  asynchronous active-low reset.
- `pN_address`  in  ADDR_W  word address; held stable while a request is pending.
- `pN_wr_enable`  in  1  write request level.
- `pN_wr_data`  in  32  write data.
- `pN_wr_mask`  in  4  byte enables; active-high.
- `pN_wr_ack`  out  1  one-cycle write completion.
- `pN_rd_enable`  in  1  read request level.
- `pN_rd_data`  out  32  read data; valid while `pN_rd_valid` is high.
- `pN_rd_valid`  out  1  one-cycle read completion.
- `mem_address`  out  ADDR_W  address toward the RAM controller.
- `mem_wr_enable`  out  1  write request level.
- `mem_wr_data`  out  32  write data toward the RAM controller.
- `mem_wr_mask`  out  4  byte enables toward the RAM controller.
- `mem_wr_ack`  in  1  RAM controller write done.
- `mem_rd_enable`  out  1  read request level.
- `mem_rd_data`  in  32  RAM controller read data.
- `mem_rd_valid`  in  1  RAM controller read done.
- `grant`  out  2  one-hot owner of the current transaction; 00 when idle.
- `timeout_err`  out  1  sticky; set on any watchdog expiry; cleared only by reset.

## Operation
- States: IDLE, WR, RD, DONE.
- **IDLE:** sample both ports.
  - A port is requesting if its `wr_enable` or `rd_enable` is high.
  - One requester: grant it.
  - Both requesting: grant the port that is not `last_grant`.
  - On a grant, register the port and operation and go to WR or RD.
- **Port with both enables high:** the write wins. The read stays pending and is served by a later grant.
- **WR / RD:**
  - `mem_*_enable` is high.
  - `mem_address`, `mem_wr_data` and `mem_wr_mask` are registered copies of the granted port's inputs, captured at grant time.
  - The watchdog counter increments each cycle.
- **Completion:** `mem_wr_ack` (in WR) or `mem_rd_valid` (in RD) sampled high.
  - Drop `mem_*_enable`.
  - Capture `mem_rd_data` into the granted port's `rd_data`.
  - Update `last_grant` and go to DONE.
- **Watchdog expiry:** counter reaches TIMEOUT with no response.
  - Same as completion, but read data is forced to 32'hFFFF_FFFF.
  - `timeout_err` is set.
- **DONE:**
  - Pulse the granted port's `wr_ack` or `rd_valid` for exactly this cycle.
  - The requester must drop its request at the edge ending DONE.
  - Return to IDLE.
- **Stray response:** `mem_wr_ack` / `mem_rd_valid` outside the matching state is ignored.
- **Outputs of a non-granted port:** `wr_ack` and `rd_valid` stay 0; `rd_data` holds its last value.

## Timing
- **Reset values:**
  - All `pN_wr_ack`, `pN_rd_valid` and `mem_*_enable` = 0.
  - `mem_address`, `mem_wr_data`, `mem_wr_mask` and `pN_rd_data` = 0.
  - `grant` = 00, `timeout_err` = 0, state = IDLE.
  - `last_grant` = port 1, so port 0 wins the first tie.
- **Latency** with the request present before edge E0 in IDLE:
  - `mem_*_enable` is high from E0.
  - With a memory response sampled at E1, the completion pulse is high from E1 to E2.
  - Minimum occupancy is 3 cycles per transaction (IDLE, WR/RD, DONE).
- **Fairness:** with both ports continuously requesting, grants alternate strictly 0,1,0,1.
- **Timeout:** the completion pulse starts TIMEOUT+1 cycles after grant.
- **Reset mid-transaction:** everything returns immediately to reset values. The lost completion is not replayed.

## Structure
- Shared defines header (`dramite_defs.vh`) holds:
  - state encodings;
  - ADDR_W default;
  - timeout fill value 32'hFFFF_FFFF.
- Sub-module `rr_pick2`: combinational two-way round-robin pick from (req[1:0], last_grant) to a one-hot grant.
- Everything else (FSM, watchdog, registers) stays in `ram_arbiter`.

## Test plan
- **Port 0 read alone:**
  - Stimulus: address 0x00100; memory answers 0xDEADBEEF one cycle after `mem_rd_enable`.
  - Required: `p0_rd_valid` is a single pulse carrying 0xDEADBEEF, 2 cycles after grant; `grant` = 01 during the transaction.
- **Simultaneous continuous requests:**
  - Stimulus: port 0 write, port 1 read, both re-requesting immediately after each completion.
  - Required: grant sequence 01,10,01,10; each port completes every 6 cycles.
- **Write passthrough:**
  - Stimulus: port 1 writes mask 4'b0011, data 0x12345678.
  - Required: `mem_wr_data`/`mem_wr_mask` match; only `p1_wr_ack` pulses; `p0_*` outputs stay 0.
- **Watchdog expiry:**
  - Stimulus: TIMEOUT=8, memory never answers a port 0 read.
  - Required: `p0_rd_valid` with 0xFFFFFFFF 9 cycles after grant; `timeout_err` = 1 and stays 1 afterwards.
- **Reset during RD:**
  - Stimulus: assert `rst_n` low while in RD.
  - Required: `mem_rd_enable`, `grant` and `p0_rd_valid` go to 0 asynchronously; after release the first tie grants port 0.
